prm_rdout_seq: RTL

Readout sequencer for the parameter-check edge-mask accumulator. On a start pulse it drives the accumulator's xyz query word and waits a programmable settle time. It then scans all 64 32-bit result words through the accumulator's `sel1`/`sel2` word-select inputs and streams them out on a valid/ready interface toward the host-side capture logic. It is the read end of the accumulator's select/result port.

---
 rtl/prm_rdout_seq_if.sv | 11 +
 rtl/prm_rdout_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prm_rdout_seq_if.sv
// Result-word stream from prm_rdout_seq toward host-side capture logic.
interface prm_rdout_seq_if;
    logic [31:0] m_data;
    logic [5:0]  m_idx;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (output m_data, m_idx, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_idx, m_valid, m_last, output m_ready);
endinterface

// File: rtl/prm_rdout_seq.sv
// Readout sequencer: loads the accumulator query word, then scans its 64 result words onto a stream.
// Define PRM_RDOUT_POPCNT_EN to accumulate the set-bit total of the scanned words on popcnt.
module prm_rdout_seq #(
    parameter int unsigned XW     = 4,
    parameter int unsigned YW     = 5,
    parameter int unsigned ZW     = 5,
    parameter int unsigned SETTLE = 2
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                start,
    input  logic [XW+YW+ZW-1:0] xyz_cfg,
    output logic                busy,
    output logic                done,
    output logic [XW+YW+ZW-1:0] xyzInput,
    output logic [1:0]          sel1,
    output logic [7:0]          sel2,
    input  logic [31:0]         result_imp,
    prm_rdout_seq_if.master     m_if,
    output logic [11:0]         popcnt
);
    localparam int unsigned QW = XW + YW + ZW;

    typedef enum logic [1:0] {IDLE, LOAD, FETCH, SEND} state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] xyz_q, xyz_d;
    logic [5:0]    idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   data_q, data_d;
    logic [5:0]    midx_q, midx_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          accept_start;

    assign accept_start = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        xyz_d   = xyz_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
        midx_d  = midx_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept_start) begin
                    state_d = LOAD;
                    xyz_d   = xyz_cfg;
                    idx_d   = '0;
                    cnt_d   = 8'(SETTLE - 1);
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                if (cnt_q == '0) state_d = FETCH;
                else             cnt_d   = cnt_q - 8'd1;
            end
            FETCH: begin
                // result_imp has had a full cycle to settle on the registered selects
                state_d = SEND;
                data_d  = result_imp;
                midx_d  = idx_q;
                last_d  = (idx_q == 6'd63);
                valid_d = 1'b1;
            end
            SEND: begin
                if (valid_q && m_if.m_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == 6'd63) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            xyz_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            midx_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xyz_q   <= xyz_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            midx_q  <= midx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign xyzInput     = xyz_q;
    assign sel1         = idx_q[5:4];
    assign sel2         = {4'b0000, idx_q[3:0]};
    assign m_if.m_data  = data_q;
    assign m_if.m_idx   = midx_q;
    assign m_if.m_valid = valid_q;
    assign m_if.m_last  = last_q;

`ifdef PRM_RDOUT_POPCNT_EN
    logic [11:0] pop_q;
    logic [5:0]  ones;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < 32; i++) ones = ones + 6'(result_imp[i]);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)                 pop_q <= '0;
        else if (accept_start)      pop_q <= '0;
        else if (state_q == FETCH)  pop_q <= pop_q + 12'(ones);
    end

    assign popcnt = pop_q;
`else
    assign popcnt = '0;
`endif
endmodule
